// File: rtl/rgen_arbiter_pkg.sv
// Shared types for the register-block command arbiter:
// FSM state enum, response status codes, index-width helper.
package rgen_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } rgen_arbiter_state_e;

  localparam logic [1:0] RGEN_STATUS_OKAY        = 2'b00;
  localparam logic [1:0] RGEN_STATUS_SLAVE_ERROR = 2'b01;

  // Width of a host index; at least one bit so NUM_HOSTS=1 still builds.
  function automatic int rgen_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgen_round_robin_arbiter.sv
// Combinational round-robin pick starting after the last grant.
// Ports: req_i (requests), last_i (last grant) -> grant_o (one-hot), grant_idx_o.
module rgen_round_robin_arbiter
  import rgen_arbiter_pkg::*;
#(
  parameter int NUM_HOSTS = 2
) (
  input  logic [NUM_HOSTS-1:0]                      req_i,
  input  logic [rgen_idx_width(NUM_HOSTS)-1:0]      last_i,
  output logic [NUM_HOSTS-1:0]                      grant_o,
  output logic [rgen_idx_width(NUM_HOSTS)-1:0]      grant_idx_o
);

  localparam int IDX_W = rgen_idx_width(NUM_HOSTS);

  always_comb begin
    int  idx;
    logic found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int i = 0; i < NUM_HOSTS; i++) begin
      idx = (int'(last_i) + 1 + i) % NUM_HOSTS;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rgen_command_arbiter.sv
// Shares one register-block command port among NUM_HOSTS host adapters.
// Ports: host command bundles in, one-hot response pulse + broadcast data/status out,
// single command out to the register block, response pulse/data/status in.
// Optional macro RGEN_ARBITER_TIMEOUT_EN adds a BUSY timeout (TIMEOUT_CYCLES).
module rgen_command_arbiter
  import rgen_arbiter_pkg::*;
#(
  parameter int NUM_HOSTS      = 2,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_HOSTS-1:0]                  i_host_command_valid,
  input  logic [NUM_HOSTS-1:0]                  i_host_write,
  input  logic [NUM_HOSTS-1:0][ADDRESS_WIDTH-1:0] i_host_address,
  input  logic [NUM_HOSTS-1:0][DATA_WIDTH-1:0]  i_host_write_data,
  output logic [NUM_HOSTS-1:0]                  o_host_response_ready,
  output logic [DATA_WIDTH-1:0]                 o_host_read_data,
  output logic [1:0]                            o_host_status,
  output logic                                  o_command_valid,
  output logic                                  o_write,
  output logic [ADDRESS_WIDTH-1:0]              o_address,
  output logic [DATA_WIDTH-1:0]                 o_write_data,
  input  logic                                  i_response_ready,
  input  logic [DATA_WIDTH-1:0]                 i_read_data,
  input  logic [1:0]                            i_status
);

  localparam int IDX_W = rgen_idx_width(NUM_HOSTS);

  rgen_arbiter_state_e state_q, state_d;
  logic [IDX_W-1:0]         grant_q, grant_d;
  logic [IDX_W-1:0]         last_q, last_d;
  logic                     write_q, write_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
  logic [1:0]               status_q, status_d;

  logic [NUM_HOSTS-1:0]     arb_grant;
  logic [IDX_W-1:0]         arb_idx;
  logic                     timeout_hit;

  rgen_round_robin_arbiter #(
    .NUM_HOSTS (NUM_HOSTS)
  ) u_rr (
    .req_i       (i_host_command_valid),
    .last_i      (last_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx)
  );

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    unique case (state_q)
      IDLE: begin
        if (|i_host_command_valid) begin
          grant_d = arb_idx;
          for (int i = 0; i < NUM_HOSTS; i++) begin
            if (arb_grant[i]) begin
              write_d = i_host_write[i];
              addr_d  = i_host_address[i];
              wdata_d = i_host_write_data[i];
            end
          end
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A real response wins over a timeout in the same cycle.
        if (i_response_ready) begin
          rdata_d  = i_read_data;
          status_d = i_status;
          last_d   = grant_q;
          state_d  = DONE;
        end else if (timeout_hit) begin
          rdata_d  = '0;
          status_d = RGEN_STATUS_SLAVE_ERROR;
          last_d   = grant_q;
          state_d  = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= IDX_W'(NUM_HOSTS - 1);
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= RGEN_STATUS_OKAY;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
    end
  end

`ifdef RGEN_ARBITER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Fires on the BUSY cycle whose increment would reach the limit.
  assign timeout_hit = (state_q == BUSY) &&
                       ((cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && state_d == BUSY) cnt_d = '0;
    else if (state_q == BUSY) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign o_command_valid = (state_q == BUSY);
  assign o_write         = write_q;
  assign o_address       = addr_q;
  assign o_write_data    = wdata_q;

  always_comb begin
    o_host_response_ready = '0;
    o_host_read_data      = '0;
    o_host_status         = RGEN_STATUS_OKAY;
    if (state_q == DONE) begin
      o_host_response_ready[grant_q] = 1'b1;
      o_host_read_data               = rdata_q;
      o_host_status                  = status_q;
    end
  end

endmodule

// File: tb/tb_rgen_command_arbiter.sv
// Directed bench for rgen_command_arbiter: vector table plus
// multi-cycle sequences (alternation, queued request, reset, timeout).
module tb_rgen_command_arbiter;
  import rgen_arbiter_pkg::*;

  localparam int NH = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NH-1:0]         hv = '0;
  logic [NH-1:0]         hw = '0;
  logic [NH-1:0][AW-1:0] ha = '0;
  logic [NH-1:0][DW-1:0] hd = '0;
  logic [NH-1:0]         rr;
  logic [DW-1:0]         rd;
  logic [1:0]            rs;
  logic                  cv;
  logic                  w;
  logic [AW-1:0]         a;
  logic [DW-1:0]         wd;
  logic                  rsp = 1'b0;
  logic [DW-1:0]         rsp_d = '0;
  logic [1:0]            rsp_s = '0;

  int total = 0;
  int bad = 0;

  rgen_command_arbiter #(
    .NUM_HOSTS      (NH),
    .ADDRESS_WIDTH  (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_host_command_valid  (hv),
    .i_host_write          (hw),
    .i_host_address        (ha),
    .i_host_write_data     (hd),
    .o_host_response_ready (rr),
    .o_host_read_data      (rd),
    .o_host_status         (rs),
    .o_command_valid       (cv),
    .o_write               (w),
    .o_address             (a),
    .o_write_data          (wd),
    .i_response_ready      (rsp),
    .i_read_data           (rsp_d),
    .i_status              (rsp_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            host;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic [1:0]    st;
    logic [NH-1:0] exp_rr;
    logic [DW-1:0] exp_rd;
    logic [1:0]    exp_st;
  } vec_t;

  vec_t tbl [5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_cv"}, 64'(cv), 0);
    chk({nm, "_w"},  64'(w),  0);
    chk({nm, "_a"},  64'(a),  0);
    chk({nm, "_wd"}, 64'(wd), 0);
    chk({nm, "_rr"}, 64'(rr), 0);
    chk({nm, "_rd"}, 64'(rd), 0);
    chk({nm, "_rs"}, 64'(rs), 0);
  endtask

  task automatic run_vec(input vec_t v);
    hv = '0;
    hv[v.host] = 1'b1;
    hw[v.host] = v.wr;
    ha[v.host] = v.addr;
    hd[v.host] = v.wdata;
    chk("v_c0_cv", 64'(cv), 0);
    step();
    chk("v_c1_cv",   64'(cv), 1);
    chk("v_c1_addr", 64'(a),  64'(v.addr));
    chk("v_c1_wr",   64'(w),  64'(v.wr));
    chk("v_c1_wd",   64'(wd), 64'(v.wdata));
    chk("v_c1_rr",   64'(rr), 0);
    step();
    chk("v_c2_cv", 64'(cv), 1);
    rsp = 1'b1; rsp_d = v.rdata; rsp_s = v.st;
    step();
    rsp = 1'b0; rsp_d = '0; rsp_s = '0;
    chk("v_c3_cv", 64'(cv), 0);
    chk("v_c3_rr", 64'(rr), 64'(v.exp_rr));
    chk("v_c3_rd", 64'(rd), 64'(v.exp_rd));
    chk("v_c3_rs", 64'(rs), 64'(v.exp_st));
    step();
    hv = '0;
    chk("v_c4_rr", 64'(rr), 0);
    chk("v_c4_rd", 64'(rd), 0);
  endtask

  initial begin
    tbl[0] = '{0, 1'b0, 16'h0010, 32'h0,        32'hDEADBEEF, 2'b00,
               2'b01, 32'hDEADBEEF, 2'b00};
    tbl[1] = '{1, 1'b1, 16'h0020, 32'h00001234, 32'h0,        2'b00,
               2'b10, 32'h0,        2'b00};
    tbl[2] = '{0, 1'b0, 16'hFFFC, 32'h0,        32'h0,        2'b01,
               2'b01, 32'h0,        2'b01};
    tbl[3] = '{1, 1'b0, 16'h0044, 32'h0,        32'hCAFEF00D, 2'b00,
               2'b10, 32'hCAFEF00D, 2'b00};
    tbl[4] = '{0, 1'b1, 16'h0008, 32'hA5A5A5A5, 32'h0,        2'b10,
               2'b01, 32'h0,        2'b10};

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Both hosts requesting: grants alternate 0,1,0,1.
    hv = 2'b11; hw = 2'b10;
    ha[0] = 16'h0100; ha[1] = 16'h0200;
    hd[0] = 32'h0;    hd[1] = 32'h00001234;
    for (int k = 0; k < 4; k++) begin
      logic e;
      e = k[0];
      step();
      chk("alt_cv",   64'(cv), 1);
      chk("alt_addr", 64'(a),  e ? 64'h0200 : 64'h0100);
      chk("alt_wd",   64'(wd), e ? 64'h1234 : 64'h0);
      chk("alt_w",    64'(w),  64'(e));
      step();
      rsp = 1'b1; rsp_d = 32'h100 + 32'(k); rsp_s = 2'b00;
      step();
      rsp = 1'b0;
      chk("alt_rr", 64'(rr), e ? 64'h2 : 64'h1);
      chk("alt_rd", 64'(rd), 64'h100 + 64'(k));
      step();
    end
    hv = '0;
    step();

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Host 1 arrives while host 0 is BUSY and waits for IDLE.
    hv = 2'b01; ha[0] = 16'h0100; ha[1] = 16'h0200;
    step();
    chk("q_c1_addr", 64'(a), 64'h0100);
    hv = 2'b11;
    step();
    rsp = 1'b1; rsp_d = 32'h55; rsp_s = 2'b00;
    step();
    rsp = 1'b0;
    chk("q_c3_rr", 64'(rr), 64'h1);
    step();
    hv = 2'b10;
    step();
    chk("q_c5_cv",   64'(cv), 1);
    chk("q_c5_addr", 64'(a),  64'h0200);
    step();
    rsp = 1'b1; rsp_d = 32'h66;
    step();
    rsp = 1'b0;
    chk("q_c7_rr", 64'(rr), 64'h2);
    chk("q_c7_rd", 64'(rd), 64'h66);
    step();
    hv = '0;

    // Response pulse while IDLE is ignored.
    rsp = 1'b1; rsp_d = 32'hFFFFFFFF; rsp_s = 2'b01;
    step();
    rsp = 1'b0; rsp_d = '0; rsp_s = '0;
    chk("idle_rsp_cv", 64'(cv), 0);
    chk("idle_rsp_rr", 64'(rr), 0);
    chk("idle_rsp_rd", 64'(rd), 0);
    chk("idle_rsp_rs", 64'(rs), 0);
    step();
    chk("idle_rsp_rr2", 64'(rr), 0);

    // Asynchronous reset during BUSY.
    hv = 2'b10; hw = 2'b11; ha[1] = 16'h0300; hd[1] = 32'h77;
    step();
    chk("rst_pre_cv", 64'(cv), 1);
    #2;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_async");
    hv = 2'b11; hw = 2'b00;
    step();
    chk("rst_hold_cv", 64'(cv), 0);
    rst = 1'b0;
    step();
    chk("rst_post_cv",   64'(cv), 1);
    chk("rst_post_addr", 64'(a),  64'h0100);
    chk("rst_post_rr",   64'(rr), 0);
    step();
    rsp = 1'b1; rsp_d = 32'h99;
    step();
    rsp = 1'b0;
    chk("rst_post_resp", 64'(rr), 64'h1);
    step();
    hv = '0;
    step();

`ifdef RGEN_ARBITER_TIMEOUT_EN
    hv = 2'b01;
    for (int i = 1; i <= TO; i++) begin
      step();
      chk("to_busy_cv", 64'(cv), 1);
    end
    step();
    chk("to_cv", 64'(cv), 0);
    chk("to_rr", 64'(rr), 64'h1);
    chk("to_rs", 64'(rs), 64'h1);
    chk("to_rd", 64'(rd), 0);
    step();
    hv = '0;
    rsp = 1'b1; rsp_d = 32'h1;
    step();
    rsp = 1'b0;
    chk("to_late_rr", 64'(rr), 0);
    chk("to_late_cv", 64'(cv), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
